yarp_dmem_resp: RTL
===================

Name: yarp_dmem_resp

Overview:
- Data-memory responder on the far end of the core's load/store port.
- Accepts one request at a time: data_req, data_wr, data_byte, address and write data.
- Holds a word-organised SRAM model and returns read data or write completion after a programmable latency.
- Reports misaligned, reserved-size and out-of-range accesses as errors; used as the LSU target in core-level simulation and FPGA builds.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; word index = addr[31:2].
- LATENCY, 2: cycles from accept to response; legal range 1..15.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- data_req_i  input  1  request valid
- data_ready_o  output  1  responder can accept this cycle
- data_wr_i  input  1  1 = store, 0 = load
- data_byte_i  input  2  size: 00 byte, 01 half-word, 11 word, 10 reserved
- data_addr_i  input  32  byte address
- data_wr_data_i  input  32  store data, LSB-aligned
- data_rvalid_o  output  1  one-cycle response pulse
- data_rd_data_o  output  32  load data, LSB-aligned, upper bits zero
- data_err_o  output  1  error flag, valid with data_rvalid_o

Behaviour:
- Reset: clk and reset are the only clock/reset; reset is asynchronous, active-high.
  - While reset is asserted: state=IDLE, counter=0, data_ready_o=1, data_rvalid_o=0, data_rd_data_o=0, data_err_o=0.
  - SRAM contents are not reset.
- Accept: occurs on the clk edge where data_req_i & data_ready_o.
  - Registers wr, size, addr, wdata.
  - Inputs are ignored when not accepted.
- States:
  - IDLE: data_ready_o=1. On accept with LATENCY=1 go to RESP; otherwise load counter with LATENCY-1 and go to WAIT.
  - WAIT: data_ready_o=0. Decrement counter; when it reaches 1 (before decrement), go to RESP.
  - RESP: data_rvalid_o=1 for exactly one cycle and data_ready_o=1. A new accept in RESP behaves as from IDLE; otherwise go to IDLE.
- Latency: the response asserts exactly LATENCY cycles after the accept edge. Peak throughput is one request per LATENCY cycles.
- Error detection (evaluated on the latched request):
  - err = (size==10) | (size==01 & addr[0]) | (size==11 & addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS).
- Error response: data_err_o=1, data_rd_data_o=0, no SRAM write.
- Store: commits in the RESP cycle, not at accept, so a reset during WAIT aborts the write.
  - Byte store: byte enable = 1 << addr[1:0]; lane gets wdata[7:0].
  - Half-word store: enables = 0011 << addr[1:0]; lanes get wdata[15:0].
  - Word store: all four lanes.
  - Response: data_rd_data_o=0, data_err_o=0.
- Load: word read in the RESP cycle; shifted right by 8*addr[1:0], then masked to 8/16/32 bits.
  - Sign or zero extension is the core's job.
- Read-after-write: a load accepted in the RESP cycle of a store to the same word sees the new data, because the store commits before the load's own RESP.
- Outputs are registered or decoded from state only; there is no combinational path from data_req_i to data_ready_o.
- Unused addr[31:2] bits beyond the DEPTH_WORDS range only feed error detection.

Test Plan:
- SW then LW, LATENCY=2:
  - Store 0xDEADBEEF to 0x10 -> rvalid 2 cycles after accept, err=0.
  - LW 0x10 -> rd_data=0xDEADBEEF.
- SB 0x5A to 0x13, then LW 0x10 -> rd_data=0x5AADBEEF.
- LH from 0x12 -> rd_data=0x00005AAD.
- LH from 0x11 -> err=1, rd_data=0.
- data_byte=10 -> err=1, memory unchanged.
- Address 0x1000 with DEPTH_WORDS=1024 -> err=1.
- LATENCY=1, req held high for 4 loads -> data_ready_o never drops; rvalid high every cycle after the first; data in order.
- SW 0x11223344 to 0x20, reset asserted in WAIT -> outputs at reset values immediately; a later LW 0x20 returns the old contents (write aborted).

Source files
------------

// File: rtl/yarp_dmem_resp.sv
// yarp_dmem_resp
//   Data-memory responder for the core's load/store port. Accepts one request
//   at a time, holds a word-organised SRAM model, and answers LATENCY cycles
//   after the accept edge with read data or store completion. Misaligned,
//   reserved-size and out-of-range accesses answer with an error and no write.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   data_req_i        request valid
//   data_ready_o      responder can accept this cycle
//   data_wr_i         1 = store, 0 = load
//   data_byte_i       size: 00 byte, 01 half-word, 11 word, 10 reserved
//   data_addr_i       byte address
//   data_wr_data_i    store data, LSB-aligned
//   data_rvalid_o     one-cycle response pulse
//   data_rd_data_o    load data, LSB-aligned, upper bits zero
//   data_err_o        error flag, valid with data_rvalid_o

module yarp_dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  output logic        data_ready_o,
  input  logic        data_wr_i,
  input  logic [1:0]  data_byte_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wr_data_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rd_data_o,
  output logic        data_err_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept;
  logic             resp;
  logic             err;
  logic [IDX_W-1:0] idx;
  logic [4:0]       shamt;
  logic [3:0]       be;
  logic [31:0]      wlane;
  logic [31:0]      rshift;
  logic [31:0]      rmasked;

  // Ready is decoded from state alone, so data_req_i never reaches it.
  assign data_ready_o = (state_q != WAIT);
  assign accept       = data_req_i & data_ready_o;
  assign resp         = (state_q == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          // A request taken in RESP starts a fresh transaction exactly as from IDLE.
          if (accept) begin
            wr_q    <= data_wr_i;
            size_q  <= data_byte_i;
            addr_q  <= data_addr_i;
            wdata_q <= data_wr_data_i;
            if (LATENCY <= 1) begin
              state_q <= RESP;
            end else begin
              cnt_q   <= 4'(LATENCY - 1);
              state_q <= WAIT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    err = (size_q == 2'b10)
        | ((size_q == 2'b01) & addr_q[0])
        | ((size_q == 2'b11) & (addr_q[1:0] != 2'b00))
        | ({2'b00, addr_q[31:2]} >= DEPTH_WORDS);
  end

  assign idx   = addr_q[IDX_W+1:2];
  assign shamt = {addr_q[1:0], 3'b000};
  assign wlane = wdata_q << shamt;

  always_comb begin
    case (size_q)
      2'b00:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = 4'b0011 << addr_q[1:0];
      default: be = 4'b1111;
    endcase
  end

  // Stores commit at the end of the RESP cycle; a reset before then drops them.
  always_ff @(posedge clk) begin
    if (resp && wr_q && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  // Loads read the array during RESP, so a store that committed at the end of
  // an earlier RESP is already visible.
  assign rshift = mem_q[idx] >> shamt;

  always_comb begin
    case (size_q)
      2'b00:   rmasked = {24'h0, rshift[7:0]};
      2'b01:   rmasked = {16'h0, rshift[15:0]};
      default: rmasked = rshift;
    endcase
  end

  assign data_rvalid_o  = resp;
  assign data_err_o     = resp & err;
  assign data_rd_data_o = (resp && !wr_q && !err) ? rmasked : '0;

endmodule
